// File: rtl/rv32i_core_pkg.sv
// Shared rv32i core types: pipeline payloads, mem-size / writeback encodings
// and the MEM-stage FSM state enum.
package rv32i_core_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'b00,
    ST_WAIT_GNT    = 2'b01,
    ST_WAIT_RVALID = 2'b10
  } mem_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [1:0]  wb_sel;
  } ex_mem_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic [31:0] wb_data;
    logic        misalign;
  } mem_wb_payload_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic res;
    case (size)
      MEM_H:   res = addr_lo[0];
      MEM_W:   res = (addr_lo != 2'b00);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational load/store alignment: byte enables, store lane replication,
// load byte/half extraction with sign or zero extension.
module rv32i_lsu_align
  import rv32i_core_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [3:0]  be_base_s;
  logic [4:0]  shamt_s;
  logic [31:0] rot_s;

  // Rotating the word means a misaligned access wraps within the word.
  always_comb begin
    shamt_s = {addr_lo, 3'b000};
    rot_s   = (rdata >> shamt_s) | (rdata << (6'd32 - {1'b0, shamt_s}));
    case (size)
      MEM_B: begin
        be_base_s = 4'b0001;
        wdata     = {4{rs2[7:0]}};
        load_data = is_unsigned ? {24'h000000, rot_s[7:0]} : {{24{rot_s[7]}}, rot_s[7:0]};
      end
      MEM_H: begin
        be_base_s = 4'b0011;
        wdata     = {2{rs2[15:0]}};
        load_data = is_unsigned ? {16'h0000, rot_s[15:0]} : {{16{rot_s[15]}}, rot_s[15:0]};
      end
      MEM_W: begin
        be_base_s = 4'b1111;
        wdata     = rs2;
        load_data = rot_s;
      end
      default: begin
        be_base_s = 4'b0000;
        wdata     = 32'h0000_0000;
        load_data = 32'h0000_0000;
      end
    endcase
    be = be_base_s << addr_lo;
  end

endmodule

// File: rtl/rv32i_mem_stage.sv
// rv32i MEM stage: req/gnt/rvalid data-memory access, writeback select, MEM/WB register.
// Optional RV32I_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of issuing them.
module rv32i_mem_stage
  import rv32i_core_pkg::*;
#(
  parameter int DMEM_AW = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  input  ex_mem_payload_t      ex_payload_i,
  output logic                 stall_o,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [DMEM_AW-1:0]   dmem_addr_o,
  output logic [3:0]           dmem_be_o,
  output logic [31:0]          dmem_wdata_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [31:0]          dmem_rdata_i,
  output logic                 mem_valid_o,
  output mem_wb_payload_t      mem_payload_o
);

  mem_state_e      state_r, state_nxt_s;
  logic            is_mem_s, mem_op_s, misalign_s, issue_s;
  logic            req_s, done_s, capture_s;
  logic [3:0]      be_s;
  logic [31:0]     wdata_s, load_data_s, wb_data_s;
  logic            mem_valid_r;
  mem_wb_payload_t payload_r;

  assign is_mem_s = ex_payload_i.mem_read || ex_payload_i.mem_write;
  // Gating with rst_ni drops req/stall the instant reset asserts mid-access.
  assign mem_op_s = rst_ni && ex_valid_i && is_mem_s;

`ifdef RV32I_MISALIGN_TRAP_EN
  assign misalign_s = mem_op_s && is_misaligned(ex_payload_i.mem_size, ex_payload_i.alu_result[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  assign issue_s = mem_op_s && !misalign_s;

  rv32i_lsu_align u_align (
    .addr_lo     (ex_payload_i.alu_result[1:0]),
    .size        (ex_payload_i.mem_size),
    .is_unsigned (ex_payload_i.mem_unsigned),
    .rs2         (ex_payload_i.rs2_data),
    .rdata       (dmem_rdata_i),
    .be          (be_s),
    .wdata       (wdata_s),
    .load_data   (load_data_s)
  );

  // Access FSM next-state, request and completion decode.
  always_comb begin
    state_nxt_s = state_r;
    req_s       = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_WAIT_GNT: begin
        if (misalign_s) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (issue_s) begin
          req_s = 1'b1;
          if (dmem_gnt_i) begin
            if (ex_payload_i.mem_write) begin
              done_s      = 1'b1;
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_WAIT_RVALID;
            end
          end else begin
            state_nxt_s = ST_WAIT_GNT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_RVALID: begin
        if (dmem_rvalid_i) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_RVALID;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Access FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign stall_o      = mem_op_s && !done_s;
  assign dmem_req_o   = req_s;
  assign dmem_we_o    = ex_valid_i ? ex_payload_i.mem_write : 1'b0;
  assign dmem_addr_o  = ex_valid_i ? ex_payload_i.alu_result[DMEM_AW-1:0] : {DMEM_AW{1'b0}};
  assign dmem_be_o    = ex_valid_i ? be_s : 4'b0000;
  assign dmem_wdata_o = ex_valid_i ? wdata_s : 32'h0000_0000;

  // Writeback select; a trapped access reports its faulting address.
  always_comb begin
    if (misalign_s) begin
      wb_data_s = ex_payload_i.alu_result;
    end else begin
      case (ex_payload_i.wb_sel)
        WB_MEM:  wb_data_s = load_data_s;
        WB_PC4:  wb_data_s = ex_payload_i.pc_plus4;
        default: wb_data_s = ex_payload_i.alu_result;
      endcase
    end
  end

  assign capture_s = done_s || (ex_valid_i && !is_mem_s);

  // MEM/WB pipeline register; payload holds while the valid bit is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_valid_r <= 1'b0;
      payload_r   <= '0;
    end else begin
      mem_valid_r <= capture_s;
      if (capture_s) begin
        payload_r.pc        <= ex_payload_i.pc;
        payload_r.rd_addr   <= ex_payload_i.rd_addr;
        payload_r.reg_write <= ex_payload_i.reg_write && !misalign_s;
        payload_r.wb_data   <= wb_data_s;
        payload_r.misalign  <= misalign_s;
      end else begin
        payload_r <= payload_r;
      end
    end
  end

  assign mem_valid_o   = mem_valid_r;
  assign mem_payload_o = payload_r;

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Self-checking bench for rv32i_mem_stage: scoreboard of expected MEM/WB payloads
// plus per-scenario bus protocol checks.
module tb_rv32i_mem_stage;
  import rv32i_core_pkg::*;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            ex_valid_i = 1'b0;
  ex_mem_payload_t ex_payload_i = '0;
  logic            stall_o, dmem_req_o, dmem_we_o;
  logic [31:0]     dmem_addr_o;
  logic [3:0]      dmem_be_o;
  logic [31:0]     dmem_wdata_o;
  logic            dmem_gnt_i = 1'b0;
  logic            dmem_rvalid_i = 1'b0;
  logic [31:0]     dmem_rdata_i = 32'h0;
  logic            mem_valid_o;
  mem_wb_payload_t mem_payload_o;

  int checks = 0;
  int failures = 0;
  mem_wb_payload_t exp_q[$];
  mem_wb_payload_t sb_exp;

  int          obs_req, obs_stall, obs_cycles;
  logic        obs_stable, obs_timeout, obs_first_req, obs_we;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata, obs_addr;

  always #5 clk = ~clk;

  rv32i_mem_stage #(.DMEM_AW(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .ex_valid_i(ex_valid_i), .ex_payload_i(ex_payload_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .mem_valid_o(mem_valid_o), .mem_payload_o(mem_payload_o)
  );

  // Scoreboard: every MEM/WB output must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_ni && mem_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%h required=none", mem_payload_o);
      end else begin
        sb_exp = exp_q.pop_front();
        if (mem_payload_o !== sb_exp) begin
          failures++;
          $display("FAIL sb_payload got=%h required=%h", mem_payload_o, sb_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic ex_mem_payload_t mk(input logic [31:0] pc, input logic [31:0] alu,
      input logic [31:0] rs2, input logic [4:0] rd, input logic rw, input logic rd_en,
      input logic wr_en, input logic [1:0] size, input logic uns, input logic [1:0] wbsel);
    ex_mem_payload_t p;
    p.pc = pc; p.pc_plus4 = pc + 32'd4; p.alu_result = alu; p.rs2_data = rs2;
    p.rd_addr = rd; p.reg_write = rw; p.mem_read = rd_en; p.mem_write = wr_en;
    p.mem_size = size; p.mem_unsigned = uns; p.wb_sel = wbsel;
    return p;
  endfunction

  function automatic mem_wb_payload_t mkexp(input logic [31:0] pc, input logic [4:0] rd,
      input logic rw, input logic [31:0] wb, input logic mis);
    mem_wb_payload_t e;
    e.pc = pc; e.rd_addr = rd; e.reg_write = rw; e.wb_data = wb; e.misalign = mis;
    return e;
  endfunction

  // Presents one op and plays the bus slave; records what the DUT did until stall drops.
  task automatic run_op(input ex_mem_payload_t p, input int gnt_wait, input int rv_wait,
                        input logic [31:0] rdata);
    bit granted;
    bit fin;
    int g0;
    granted = 1'b0; fin = 1'b0; g0 = 0;
    obs_req = 0; obs_stall = 0; obs_cycles = 0; obs_stable = 1'b1; obs_first_req = 1'b0;
    obs_be = 4'h0; obs_wdata = 32'h0; obs_addr = 32'h0; obs_we = 1'b0;
    ex_valid_i = 1'b1; ex_payload_i = p; dmem_rdata_i = rdata;
    for (int cyc = 0; cyc < 30 && !fin; cyc++) begin
      dmem_gnt_i    = (!granted && cyc == gnt_wait);
      dmem_rvalid_i = (granted && cyc == g0 + rv_wait);
      @(negedge clk);
      if (cyc == 0) obs_first_req = dmem_req_o;
      if (dmem_req_o) begin
        if (obs_req == 0) begin
          obs_be = dmem_be_o; obs_wdata = dmem_wdata_o; obs_addr = dmem_addr_o; obs_we = dmem_we_o;
        end else if (obs_be !== dmem_be_o || obs_wdata !== dmem_wdata_o ||
                     obs_addr !== dmem_addr_o || obs_we !== dmem_we_o) begin
          obs_stable = 1'b0;
        end
        obs_req++;
      end
      if (stall_o) obs_stall++;
      else fin = 1'b1;
      if (dmem_gnt_i) begin
        granted = 1'b1;
        g0 = cyc;
      end
      obs_cycles = cyc + 1;
      @(posedge clk); #1;
    end
    obs_timeout = !fin;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; ex_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (mem_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b required=0", mem_valid_o); end
    checks++; if (mem_payload_o !== '0) begin failures++; $display("FAIL rst_payload got=%h required=0", mem_payload_o); end
    checks++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL rst_req_stall got=%b%b required=00", dmem_req_o, stall_o); end
    checks++;
    if ({dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o} !== 69'h0) begin
      failures++; $display("FAIL idle_bus got=%b/%h/%h/%h required=0", dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o);
    end
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_alu_ops();
    ex_valid_i = 1'b1;
    ex_payload_i = mk(32'h40, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, MEM_W, 1'b0, WB_ALU);
    exp_q.push_back(mkexp(32'h40, 5'd5, 1'b1, 32'h1234, 1'b0));
    @(negedge clk);
    checks++; if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin failures++; $display("FAIL alu_nostall got=%b%b required=00", stall_o, dmem_req_o); end
    @(posedge clk); #1;
    ex_payload_i = mk(32'h44, 32'h999, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, MEM_W, 1'b0, WB_PC4);
    exp_q.push_back(mkexp(32'h44, 5'd1, 1'b1, 32'h48, 1'b0));
    @(negedge clk);
    checks++; if (mem_valid_o !== 1'b1 || stall_o !== 1'b0) begin failures++; $display("FAIL alu_latency got=%b%b required=10", mem_valid_o, stall_o); end
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (mem_valid_o !== 1'b1) begin failures++; $display("FAIL pc4_latency got=%b required=1", mem_valid_o); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (mem_valid_o !== 1'b0) begin failures++; $display("FAIL alu_bubble got=%b required=0", mem_valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_wait();
    exp_q.push_back(mkexp(32'h50, 5'd0, 1'b0, 32'h100, 1'b0));
    run_op(mk(32'h50, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, MEM_W, 1'b0, WB_ALU), 2, 1, 32'h0);
    ex_valid_i = 1'b0;
    checks++; if (obs_timeout) begin failures++; $display("FAIL sw_timeout got=1 required=0"); end
    checks++; if (obs_req != 3 || obs_stall != 2) begin failures++; $display("FAIL sw_req_stall got=%0d/%0d required=3/2", obs_req, obs_stall); end
    checks++; if (!obs_stable) begin failures++; $display("FAIL sw_stable got=0 required=1"); end
    checks++;
    if (obs_be !== 4'b1111 || obs_wdata !== 32'hDEADBEEF || obs_addr !== 32'h100 || obs_we !== 1'b1) begin
      failures++; $display("FAIL sw_bus got=%b/%h/%h/%b required=1111/deadbeef/00000100/1", obs_be, obs_wdata, obs_addr, obs_we);
    end
    @(negedge clk);
    checks++; if (mem_valid_o !== 1'b1) begin failures++; $display("FAIL sw_done got=%b required=1", mem_valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_ext();
    for (int u = 0; u < 2; u++) begin
      exp_q.push_back(mkexp(32'h60, 5'd7, 1'b1, (u == 1) ? 32'h00000080 : 32'hFFFFFF80, 1'b0));
      run_op(mk(32'h60, 32'h101, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, MEM_B, u[0], WB_MEM), 0, 1, 32'h00008000);
      ex_valid_i = 1'b0;
      checks++;
      if (obs_timeout || obs_req != 1 || obs_stall != 1 || obs_cycles != 2 || obs_be !== 4'b0010 || obs_we !== 1'b0) begin
        failures++; $display("FAIL lb_bus u=%0d got=%0d/%0d/%0d/%b required=1/1/2/0010", u, obs_req, obs_stall, obs_cycles, obs_be);
      end
      @(negedge clk);
      checks++; if (mem_valid_o !== 1'b1) begin failures++; $display("FAIL lb_latency u=%0d got=%b required=1", u, mem_valid_o); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_half();
    exp_q.push_back(mkexp(32'h70, 5'd0, 1'b0, 32'h202, 1'b0));
    run_op(mk(32'h70, 32'h202, 32'h0000ABCD, 5'd0, 1'b0, 1'b0, 1'b1, MEM_H, 1'b0, WB_ALU), 0, 1, 32'h0);
    ex_valid_i = 1'b0;
    checks++;
    if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCDABCD || obs_req != 1 || obs_stall != 0) begin
      failures++; $display("FAIL sh_bus got=%b/%h/%0d/%0d required=1100/abcdabcd/1/0", obs_be, obs_wdata, obs_req, obs_stall);
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
`ifdef RV32I_MISALIGN_TRAP_EN
    exp_q.push_back(mkexp(32'h80, 5'd9, 1'b0, 32'h102, 1'b1));
    run_op(mk(32'h80, 32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, MEM_W, 1'b0, WB_MEM), 99, 1, 32'h11223344);
    ex_valid_i = 1'b0;
    checks++;
    if (obs_req != 0 || obs_stall != 0 || obs_cycles != 1) begin
      failures++; $display("FAIL lw_trap got=%0d/%0d/%0d required=0/0/1", obs_req, obs_stall, obs_cycles);
    end
`else
    exp_q.push_back(mkexp(32'h80, 5'd9, 1'b1, 32'h33441122, 1'b0));
    run_op(mk(32'h80, 32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, MEM_W, 1'b0, WB_MEM), 0, 1, 32'h11223344);
    ex_valid_i = 1'b0;
    checks++;
    if (obs_req != 1 || obs_be !== 4'b1100 || obs_addr !== 32'h102) begin
      failures++; $display("FAIL lw_misalign_bus got=%0d/%b/%h required=1/1100/00000102", obs_req, obs_be, obs_addr);
    end
`endif
    @(negedge clk);
    checks++; if (mem_valid_o !== 1'b1) begin failures++; $display("FAIL lw_misalign_done got=%b required=1", mem_valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(mkexp(32'h90, 5'd0, 1'b0, 32'h303, 1'b0));
    exp_q.push_back(mkexp(32'h94, 5'd11, 1'b1, 32'hFFFFBEEF, 1'b0));
    run_op(mk(32'h90, 32'h303, 32'h0000005A, 5'd0, 1'b0, 1'b0, 1'b1, MEM_B, 1'b0, WB_ALU), 0, 1, 32'h0);
    checks++;
    if (obs_be !== 4'b1000 || obs_wdata !== 32'h5A5A5A5A) begin
      failures++; $display("FAIL sb_bus got=%b/%h required=1000/5a5a5a5a", obs_be, obs_wdata);
    end
    run_op(mk(32'h94, 32'h302, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, MEM_H, 1'b0, WB_MEM), 1, 2, 32'hBEEF0000);
    ex_valid_i = 1'b0;
    checks++;
    if (!obs_first_req || obs_req != 2 || obs_stall != 3 || obs_cycles != 4 || obs_be !== 4'b1100) begin
      failures++; $display("FAIL b2b_lh got=%b/%0d/%0d/%0d/%b required=1/2/3/4/1100", obs_first_req, obs_req, obs_stall, obs_cycles, obs_be);
    end
    @(negedge clk);
    checks++; if (mem_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b required=1", mem_valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    ex_valid_i = 1'b1;
    ex_payload_i = mk(32'hA0, 32'h400, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, MEM_W, 1'b0, WB_MEM);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b1 || stall_o !== 1'b1) begin failures++; $display("FAIL rm_issue got=%b%b required=11", dmem_req_o, stall_o); end
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    @(negedge clk); #1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || mem_valid_o !== 1'b0) begin
      failures++; $display("FAIL rm_abort got=%b%b%b required=000", dmem_req_o, stall_o, mem_valid_o);
    end
    ex_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    @(negedge clk);
    checks++; if (mem_valid_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL rm_late_rvalid got=%b%b required=00", mem_valid_o, stall_o); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_store_wait();
    test_load_ext();
    test_store_half();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d required=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_stage.md
# rv32i_mem_stage

Memory-access stage of the rv32i five-stage pipeline. It consumes the EX/MEM payload (`ex_mem_payload_t`) and runs loads and stores over a req/gnt/rvalid data-memory port. It also selects the writeback value and registers the result into the MEM/WB payload (`mem_wb_payload_t`). Upstream stages are stalled while a bus access is outstanding.

## Interface
Parameters:
- `DMEM_AW`, default 32: data-memory address width; `dmem_addr_o` = `alu_result[DMEM_AW-1:0]`.

Ports:
- `clk_i` input 1: clock; one clock domain only.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `ex_valid_i` input 1: EX/MEM payload valid.
- `ex_payload_i` input `ex_mem_payload_t`: registered EX/MEM payload; held stable by upstream while `stall_o`=1.
- `stall_o` output 1: freezes PC/IF/ID/EX and the EX/MEM register.
- `dmem_req_o` output 1: bus request.
- `dmem_we_o` output 1: 1 = store.
- `dmem_addr_o` output `DMEM_AW`: byte address.
- `dmem_be_o` output 4: byte enables.
- `dmem_wdata_o` output 32: store data, lane-replicated.
- `dmem_gnt_i` input 1: request accepted this cycle.
- `dmem_rvalid_i` input 1: load data valid.
- `dmem_rdata_i` input 32: load data word.
- `mem_valid_o` output 1: MEM/WB valid, registered.
- `mem_payload_o` output `mem_wb_payload_t`: registered fields `pc`, `rd_addr`, `reg_write`, `wb_data`, `misalign`.

## Operation
- Memory op = `ex_valid_i && (mem_read || mem_write)`. All other valid ops pass straight to MEM/WB with no stall.
- FSM states:
  - IDLE: memory op present → `dmem_req_o`=1. On `gnt`: store → done; load → WAIT_RVALID. No `gnt` → WAIT_GNT.
  - WAIT_GNT: `dmem_req_o`=1, with addr/we/be/wdata unchanged. On `gnt`: store → done, back to IDLE; load → WAIT_RVALID.
  - WAIT_RVALID: `dmem_req_o`=0. On `rvalid` → done, back to IDLE.
- `dmem_rvalid_i` is ignored in IDLE and WAIT_GNT.
- Store completes on its `gnt`. Load completes on `rvalid`, which arrives at the earliest one cycle after `gnt`.
- `stall_o` = memory op && !done this cycle. The stall is combinational, so no extra bubble is added.
- Byte enables: B=`4'b0001`, H=`4'b0011`, W=`4'b1111`, shifted left by `addr[1:0]` and truncated to 4 bits.
- Store data: B → `{4{rs2[7:0]}}`, H → `{2{rs2[15:0]}}`, W → `rs2`.
- Load data: select byte/half at `addr[1:0]` from `rdata`. Then sign-extend, or zero-extend when `mem_unsigned`.
- `wb_data`: WB_MEM → aligned load data; WB_PC4 → `pc_plus4`; otherwise → `alu_result`.
- MEM/WB register: on done or on a non-memory valid op, capture the payload and set `mem_valid_o`=1. Otherwise `mem_valid_o`=0 next cycle, which inserts a bubble during stalls. Payload fields hold their last value while invalid.

## Timing
- Reset values: `mem_valid_o`=0, `mem_payload_o`='0, state IDLE, `dmem_req_o`=0, `stall_o`=0.
- When `ex_valid_i`=0, the bus outputs `dmem_we_o`, `dmem_be_o`, `dmem_addr_o` and `dmem_wdata_o` drive 0.
- Non-memory op: 1-cycle latency.
- Store with same-cycle `gnt`: 1 cycle.
- Load with `gnt` at cycle 0 and `rvalid` at cycle N: `mem_valid_o`=1 at cycle N+1.
- `gnt` and `rvalid` for different requests never overlap, because only one access is outstanding at a time.
- Reset asserted mid-access: immediate return to IDLE, `req` drops, and the outstanding response is discarded by rule.
- Back-to-back memory ops: the next op is presented in the cycle after done and is requested in that same cycle from IDLE.

## Configuration
- `RV32I_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are never issued on the bus: H with `addr[0]`=1, or W with `addr[1:0]`≠0.
  - Such an op completes in 1 cycle with `misalign`=1, `reg_write` forced 0, and `mem_valid_o`=1.
- Not defined:
  - No check is made; `misalign` is tied 0.
  - The access is issued with truncated byte enables, and data wraps within the word.

## Structure
- Shared package (`rv32i_core_pkg`) holds:
  - `mem_wb_payload_t`;
  - the mem-size encoding MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10;
  - the `wb_sel` constants WB_ALU, WB_MEM, WB_PC4;
  - the FSM state enum `mem_state_e`.
- One combinational sub-module, `rv32i_lsu_align`, computes byte enables, store replication, and load extraction/extension.

## Test plan
- ADD result `0x1234`, WB_ALU, no memory op → `mem_valid_o`=1 next cycle, `wb_data`=`0x1234`, `stall_o` never 1.
- SW addr `0x100`, rs2 `0xDEADBEEF`, `gnt` delayed 2 cycles → `req` held 3 cycles with stable addr/`be=1111`/`wdata`; `stall_o`=1 for 2 cycles; then `mem_valid_o`=1.
- LB addr `0x101`, `rdata` `0x00008000`, `rvalid` 1 cycle after `gnt` → `wb_data`=`0xFFFFFF80`. LBU, same stimulus → `0x00000080`.
- SH addr `0x202`, rs2 `0x0000ABCD` → `be`=`1100`, `wdata`=`0xABCDABCD`.
- LW with `gnt`, then `rst_ni` low before `rvalid`:
  - response: `req`/`stall`/`mem_valid` all 0 immediately;
  - a late `rvalid` after reset release is ignored.
- LW addr `0x102`:
  - with `RV32I_MISALIGN_TRAP_EN`: no `req`, `misalign`=1, `reg_write`=0, 1-cycle latency;
  - without it: request issued with `be`=`1100`.
